// File: rtl/wptr_full_if.sv
// Write-side pointer bus between the write-domain user/RAM and wptr_full.
//   winc          write request for this cycle
//   wq2_read_ptr  Gray read pointer, already synchronized into wclk
//   waddr         RAM write address (binary write pointer without its MSB)
//   wptr          registered Gray write pointer toward the read-side synchronizer
//   wfull         FIFO full
//   walmost_full  free entries at or below the almost-full margin
//   wlevel        occupancy seen from the write side, 0..DEPTH
//   wovf          sticky overflow (write attempted while full)
// master: the side that requests writes; slave: wptr_full itself.
interface wptr_full_if #(
  parameter int unsigned ADDRESS_BITS = 9
);
  logic                    winc;
  logic [ADDRESS_BITS:0]   wq2_read_ptr;
  logic [ADDRESS_BITS-1:0] waddr;
  logic [ADDRESS_BITS:0]   wptr;
  logic                    wfull;
  logic                    walmost_full;
  logic [ADDRESS_BITS:0]   wlevel;
  logic                    wovf;

  modport master (
    output winc, wq2_read_ptr,
    input  waddr, wptr, wfull, walmost_full, wlevel, wovf
  );

  modport slave (
    input  winc, wq2_read_ptr,
    output waddr, wptr, wfull, walmost_full, wlevel, wovf
  );
endinterface

// File: rtl/wptr_full.sv
// Async FIFO write-side pointer and flag generator, entirely in the wclk domain.
// Counts accepted writes, drives the RAM write address, publishes a Gray write
// pointer, and derives full / almost-full / level / overflow from the
// synchronized Gray read pointer.
//   wclk  write-domain clock
//   wrst  asynchronous active-low reset
//   bus   wptr_full_if slave modport (winc, wq2_read_ptr in; status out)
module wptr_full #(
  parameter int unsigned ADDRESS_BITS       = 9,
  parameter int unsigned ALMOST_FULL_MARGIN = 4
) (
  input  logic         wclk,
  input  logic         wrst,
  wptr_full_if.slave   bus
);

  localparam int unsigned A         = ADDRESS_BITS;
  localparam int unsigned PTR_W     = ADDRESS_BITS + 1;
  localparam int unsigned DEPTH     = 1 << ADDRESS_BITS;
  localparam int unsigned AF_THRESH = DEPTH - ALMOST_FULL_MARGIN;

  logic [PTR_W-1:0] wbin_q, wbin_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] wlevel_q, wlevel_d;
  logic             wfull_q, wfull_d;
  logic             walmost_full_q, walmost_full_d;
  logic             wovf_q, wovf_d;

  logic             we_c;
  logic [PTR_W-1:0] rbin_c;
  logic [PTR_W-1:0] full_ptr_c;

  // Next-state: pointer advance, read-pointer decode and flag computation
  always_comb begin
    we_c           = 1'b0;
    rbin_c         = '0;
    full_ptr_c     = '0;
    wbin_d         = wbin_q;
    wptr_d         = wptr_q;
    wlevel_d       = wlevel_q;
    wfull_d        = wfull_q;
    walmost_full_d = walmost_full_q;
    wovf_d         = wovf_q;

    // Writes while full are dropped; pointer, address and wptr hold
    we_c = bus.winc & ~wfull_q;

    // Gray-to-binary: each bit is the XOR of itself and all higher bits
    for (int i = 0; i < int'(PTR_W); i++) begin
      rbin_c[i] = ^(bus.wq2_read_ptr >> i);
    end

    wbin_d = wbin_q + PTR_W'(we_c);
    wptr_d = (wbin_d >> 1) ^ wbin_d;

    // Full when write is exactly one lap ahead: top two Gray bits inverted
    full_ptr_c = {~bus.wq2_read_ptr[A:A-1], bus.wq2_read_ptr[A-2:0]};
    wfull_d    = (wptr_d == full_ptr_c);

    wlevel_d       = wbin_d - rbin_c;
    walmost_full_d = (wlevel_d >= PTR_W'(AF_THRESH));
    wovf_d         = wovf_q | (bus.winc & wfull_q);
  end

  // State registers
  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      wbin_q         <= '0;
      wptr_q         <= '0;
      wlevel_q       <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      wovf_q         <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      wptr_q         <= wptr_d;
      wlevel_q       <= wlevel_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      wovf_q         <= wovf_d;
    end
  end

  // Outputs come straight from registers; waddr drops the lap bit
  assign bus.waddr        = wbin_q[A-1:0];
  assign bus.wptr         = wptr_q;
  assign bus.wfull        = wfull_q;
  assign bus.walmost_full = walmost_full_q;
  assign bus.wlevel       = wlevel_q;
  assign bus.wovf         = wovf_q;

endmodule

// File: doc/wptr_full.md
# wptr_full

Write-side pointer and flag generator for the async FIFO, running entirely in the write clock domain. It counts accepted writes, produces the RAM write address, and publishes a Gray-coded write pointer for `sync_w_to_r`. It consumes the two-flop-synchronized read pointer from `sync_r_to_w` and derives the full, almost-full, level and overflow status from it.

## Interface
- `ADDRESS_BITS`, 9: RAM address width. Depth = 2^ADDRESS_BITS. Pointers are ADDRESS_BITS+1 bits wide. Legal values are ≥ 2.
- `ALMOST_FULL_MARGIN`, 4: `walmost_full` asserts when free entries ≤ this value. Legal range is 1..DEPTH-1.
- `wclk`  in  1  write-domain clock. This block has one clock, `wclk`.
- `wrst`  in  1  reset. Asynchronous, active-low.
- `winc`  in  1  write request for this cycle.
- `wq2_read_ptr`  in  ADDRESS_BITS+1  Gray read pointer, already synchronized into `wclk`.
- `waddr`  out  ADDRESS_BITS  RAM write address. Equals the binary write pointer with the MSB dropped.
- `wptr`  out  ADDRESS_BITS+1  Gray write pointer, registered. Feeds `sync_w_to_r`.
- `wfull`  out  1  FIFO full, registered.
- `walmost_full`  out  1  level ≥ DEPTH − ALMOST_FULL_MARGIN, registered.
- `wlevel`  out  ADDRESS_BITS+1  occupancy as seen from the write side, range 0..DEPTH, registered.
- `wovf`  out  1  sticky overflow. Set by a write attempt while full.

## Operation
- Internal binary pointer `wbin` is ADDRESS_BITS+1 bits.
- Write accept: `we = winc & ~wfull`.
- `wbin_next = wbin + we`. Wraps modulo 2^(ADDRESS_BITS+1).
- `wgray_next = (wbin_next >> 1) ^ wbin_next`.
- Each edge registers `wbin <= wbin_next` and `wptr <= wgray_next`.
- `waddr = wbin[ADDRESS_BITS-1:0]`, taken from the register (no combinational path from `winc`). The RAM writes at `waddr` when `we` is high.
- Full compare, registered:
  - `wfull <= (wgray_next == {~wq2_read_ptr[A:A-1], wq2_read_ptr[A-2:0]})`, where A = ADDRESS_BITS.
- Read-pointer decode, combinational: `rbin[i] = ^wq2_read_ptr[A:i]`.
- Level: `wlevel <= wbin_next − rbin`, modulo 2^(A+1). The result is always ≤ DEPTH.
- Almost-full: `walmost_full <= (wbin_next − rbin) ≥ DEPTH − ALMOST_FULL_MARGIN`.
- Overflow: `wovf <= wovf | (winc & wfull)`. It clears only on reset.
- A write attempted while full is dropped: the pointer, address and `wptr` hold.
- Simultaneous write and read-pointer advance: both are applied in the same edge. Level is unchanged net; `wfull` is recomputed from both.
- Reset (`wrst` low, asynchronous assert, any time including mid-burst) forces `wbin`, `wptr`, `waddr`, `wfull`, `walmost_full`, `wlevel` and `wovf` to 0. The synchronizers reset to 0 as well, so a system reset produces a consistent empty state.

## Timing
- `wptr` changes at most 1 bit per edge. It is glitch-free as seen by `sync_w_to_r`.
- Write-to-flag latency is 0 extra cycles. The edge that accepts the DEPTH-th outstanding write also sets `wfull`.
- Read-to-flag latency: a read-pointer change reaches `wq2_read_ptr` after 2 `wclk` edges (synchronizer). `wfull`, `walmost_full` and `wlevel` update on the following edge. Deassertion of full is therefore pessimistic by up to 3 `wclk` cycles; this is intended.
- Reset release: the first write can be accepted on the first `wclk` edge after `wrst` rises.

## Test plan
- Reset: hold `wrst`=0 with `winc`=1 and random `wq2_read_ptr` → all outputs stay 0. Release `wrst` with `winc`=0 → outputs remain 0.
- Fill, with defaults and `wq2_read_ptr`=0, `winc`=1 for 512 cycles:
  - `walmost_full` rises on the 508th accepted edge, when `wlevel`=508.
  - `wfull` rises on the 512th edge, with `wlevel`=512, `wptr`=10'h300 and `waddr`=0.
- Overflow: continue `winc`=1 while full for 3 cycles → `wptr`, `waddr` and `wlevel` are unchanged. `wovf`=1 on the next edge and stays 1 after `winc` drops.
- Drain: from full, set `wq2_read_ptr`=Gray(1)=10'h001 → next edge `wfull`=0 and `wlevel`=511. Set it to Gray(8)=10'h00C → `walmost_full`=0 and `wlevel`=504.
- Wrap-around: model the read pointer tracking the write pointer at a lag of 10, for 1100 writes. Check:
  - `wptr` returns to 0 after 1024 writes;
  - `wptr` changes by exactly 1 bit per accepted write;
  - `wfull` is never set, and `wlevel`=10 throughout.
- Async reset mid-burst: pulse `wrst` low for half a `wclk` period during the write at `waddr`=37 → outputs go to 0 immediately, without waiting for a clock edge. The next write after release uses `waddr`=0.
